alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 16-bit adder/subtractor.

---
 rtl/kolache_alu_pkg.sv | 24 ++
 rtl/alu_flag_gen.sv | 45 ++++
 rtl/alu_result_stage.sv | 149 ++++++++++++++
 tb/tb_alu_result_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kolache_alu_pkg.sv
// Shared types and constants for the ALU result stage.
package kolache_alu_pkg;

    localparam int ALU_WIDTH = 16;

    // Bit positions inside the 4-bit {Z,N,C,V} flag vector
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    // Field order matches the FLG_* indices when viewed as logic [3:0]
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    // Saturation bounds for the default datapath width
    localparam logic [ALU_WIDTH-1:0] SAT_MAX = {1'b0, {(ALU_WIDTH-1){1'b1}}};
    localparam logic [ALU_WIDTH-1:0] SAT_MIN = {1'b1, {(ALU_WIDTH-1){1'b0}}};

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation and optional saturation of the adder result.
// Optional feature macro: KOLACHE_ALU_SAT_EN (clamp result on signed overflow).
module alu_flag_gen
    import kolache_alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             mode,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

`ifdef KOLACHE_ALU_SAT_EN
    localparam logic [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic ovf;

    // Signed overflow uses b's sign before the subtract inversion, so the
    // add and subtract cases differ in which operand-sign relation matters.
    always_comb begin
        if (mode)
            ovf = (a_msb != b_msb) && (sum[WIDTH-1] != a_msb);
        else
            ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);

        result = sum;
`ifdef KOLACHE_ALU_SAT_EN
        // Overflow always moves away from a's sign, so a's sign picks the rail
        if (ovf)
            result = a_msb ? SAT_LO : SAT_HI;
`endif

        flags.z = (result == '0);
        flags.n = result[WIDTH-1];
        flags.c = cout ^ mode;   // borrow is the inverted carry when subtracting
        flags.v = ovf;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the adder: flag capture plus a small result
// FIFO with valid/ready on both sides. in_ready depends only on stored count.
// Optional feature macro: KOLACHE_ALU_SAT_EN (handled inside alu_flag_gen).
module alu_result_stage
    import kolache_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    input  logic             in_mode,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [15:0]      res_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH != 2 && DEPTH != 4) begin : g_depth_chk
        $error("alu_result_stage: DEPTH must be 2 or 4");
    end

    logic [WIDTH-1:0]             gen_result;
    alu_flags_t                   gen_flags;

    logic [DEPTH-1:0][WIDTH-1:0]  mem_result;
    alu_flags_t [DEPTH-1:0]       mem_flags;
    logic [DEPTH-1:0][TAG_W-1:0]  mem_tag;

    logic [PTR_W-1:0]             wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]             count, count_nxt;
    logic                         push, pop;

    logic [WIDTH-1:0]             head_result;
    alu_flags_t                   head_flags;
    logic [TAG_W-1:0]             head_tag;

    logic [WIDTH-1:0]             out_result_q;
    alu_flags_t                   out_flags_q;
    logic [TAG_W-1:0]             out_tag_q;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .sum    (in_sum),
        .cout   (in_cout),
        .mode   (in_mode),
        .a_msb  (in_a_msb),
        .b_msb  (in_b_msb),
        .result (gen_result),
        .flags  (gen_flags)
    );

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next occupancy and next head, including the bypass of a new entry that
    // becomes the head in the same cycle it is written
    always_comb begin
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

        if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_result = gen_result;
            head_flags  = gen_flags;
            head_tag    = in_tag;
        end else begin
            head_result = mem_result[rd_ptr_nxt];
            head_flags  = mem_flags[rd_ptr_nxt];
            head_tag    = mem_tag[rd_ptr_nxt];
        end
    end

    // Pointer and occupancy state; pointers wrap naturally at power-of-two DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_result[wr_ptr] <= gen_result;
            mem_flags[wr_ptr]  <= gen_flags;
            mem_tag[wr_ptr]    <= in_tag;
        end
    end

    // Output register tracks the next head and freezes when the FIFO drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_q <= '0;
            out_flags_q  <= '0;
            out_tag_q    <= '0;
        end else if (count_nxt != '0) begin
            out_result_q <= head_result;
            out_flags_q  <= head_flags;
            out_tag_q    <= head_tag;
        end
    end

    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign out_tag    = out_tag_q;

    // Overflow sticky (set beats clear) and wrapping accepted-result counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            res_cnt    <= '0;
        end else begin
            if (push && gen_flags.v)
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;
            if (push)
                res_cnt <= res_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected entries are modelled from the
// raw operands when a push is accepted and compared when the DUT pops them.
module tb_alu_result_stage;
    import kolache_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sum = '0;
    logic        in_cout = 1'b0;
    logic        in_mode = 1'b0;
    logic        in_a_msb = 1'b0;
    logic        in_b_msb = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  out_tag;
    logic        ovf_sticky;
    logic        ovf_clr = 1'b0;
    logic [15:0] res_cnt;

    int vectors = 0;
    int miscompares = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    exp_t        q[$];
    logic [15:0] cur_a = '0, cur_b = '0;
    logic        cur_mode = 1'b0;

    alu_result_stage #(.WIDTH(16), .DEPTH(2), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_mode    (in_mode),
        .in_a_msb   (in_a_msb),
        .in_b_msb   (in_b_msb),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .out_tag    (out_tag),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .res_cnt    (res_cnt)
    );

    always #5 clk = ~clk;

    // Reference result from signed integer arithmetic on the raw operands
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic m, input logic [3:0] t);
        exp_t e;
        int   sa, sb, r;
        logic v, c;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = m ? sa - sb : sa + sb;
        v  = (r > 32767) || (r < -32768);
        c  = m ? (a < b) : ((int'(a) + int'(b)) > 65535);
        e.res = r[15:0];
`ifdef KOLACHE_ALU_SAT_EN
        if (v) e.res = (r > 0) ? SAT_MAX : SAT_MIN;
`endif
        e.flg = {(e.res == 16'h0000), e.res[15], c, v};
        e.tag = t;
        return e;
    endfunction

    // Plays the adder: drives sum/carry and operand signs for a, b, mode
    task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input logic [3:0] t);
        logic [16:0] s;
        s = m ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
        cur_a = a; cur_b = b; cur_mode = m;
        in_valid = v; in_tag = t;
        in_sum = s[15:0]; in_cout = s[16]; in_mode = m;
        in_a_msb = a[15]; in_b_msb = b[15];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop/compare on accepted output, push model on accepted input
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected got res=%h flg=%b tag=%h want none",
                             out_result, out_flags, out_tag);
                end else begin
                    e = q.pop_front();
                    if ({out_result, out_flags, out_tag} !== {e.res, e.flg, e.tag}) begin
                        miscompares++;
                        $display("FAIL out_entry got res=%h flg=%b tag=%h want res=%h flg=%b tag=%h",
                                 out_result, out_flags, out_tag, e.res, e.flg, e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(cur_a, cur_b, cur_mode, in_tag));
                exp_cnt++;
            end
        end
    end

    task automatic drain();
        int n;
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        @(negedge clk);
        vectors++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_timeout got q=%0d out_valid=%b want q=0 out_valid=0",
                     q.size(), out_valid);
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready, ovf_sticky} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_ctrl got v=%b r=%b ovf=%b want v=0 r=1 ovf=0",
                     out_valid, in_ready, ovf_sticky);
        end
        vectors++;
        if ({out_result, out_flags, out_tag, res_cnt} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_data got res=%h flg=%b tag=%h cnt=%h want all 0",
                     out_result, out_flags, out_tag, res_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
    endtask

    // Directed flag vectors, each pushed alone so its head values are visible
    task automatic test_flags();
        logic [15:0] want_res;
        logic [3:0]  want_flg;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin
                    set_in(1'b1, 16'h7FFF, 16'h0001, 1'b0, 4'h1);
`ifdef KOLACHE_ALU_SAT_EN
                    want_res = 16'h7FFF; want_flg = 4'b0001;
`else
                    want_res = 16'h8000; want_flg = 4'b0101;
`endif
                end
                1: begin
                    set_in(1'b1, 16'h0005, 16'h0005, 1'b1, 4'h2);
                    want_res = 16'h0000; want_flg = 4'b1000;
                end
                default: begin
                    set_in(1'b1, 16'h0000, 16'h0001, 1'b1, 4'h3);
                    want_res = 16'hFFFF; want_flg = 4'b0110;
                end
            endcase
            step();
            set_in(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
            @(negedge clk);
            vectors++;
            if ({out_valid, out_result, out_flags} !== {1'b1, want_res, want_flg}) begin
                miscompares++;
                $display("FAIL flags_%0d got v=%b res=%h flg=%b want v=1 res=%h flg=%b",
                         i, out_valid, out_result, out_flags, want_res, want_flg);
            end
            if (i == 0) begin
                vectors++;
                if (ovf_sticky !== 1'b1) begin
                    miscompares++;
                    $display("FAIL flags_ovf_sticky got %b want 1", ovf_sticky);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int base;
        base = exp_cnt;
        out_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            set_in(1'b1, 16'(t * 16'h0101), 16'h0010, 1'b0, 4'(t));
            step();
        end
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 4'h1} || res_cnt !== 16'(base + 2)) begin
            miscompares++;
            $display("FAIL full_state got r=%b v=%b tag=%h cnt=%0d want r=0 v=1 tag=1 cnt=%0d",
                     in_ready, out_valid, out_tag, res_cnt, base + 2);
        end
        // Offer a push while full and popping: it must be ignored
        step();
        set_in(1'b1, 16'h1234, 16'h0001, 1'b0, 4'h9);
        out_ready = 1'b1;
        step();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_tag} !== {1'b1, 4'h2} || res_cnt !== 16'(base + 2)) begin
            miscompares++;
            $display("FAIL full_pop got r=%b tag=%h cnt=%0d want r=1 tag=2 cnt=%0d",
                     in_ready, out_tag, res_cnt, base + 2);
        end
        drain();
    endtask

    task automatic test_ovf();
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_a got %b want 0", ovf_sticky);
        end
        step();
        set_in(1'b1, 16'h8000, 16'h0001, 1'b1, 4'h5);
        ovf_clr = 1'b1;
        step();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        ovf_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set_wins got %b want 1", ovf_sticky);
        end
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear_b got %b want 0", ovf_sticky);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            set_in(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), 4'($urandom));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();
        vectors++;
        if (res_cnt !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL random_res_cnt got %0d want %0d", res_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_in(1'b1, 16'h0001, 16'h0002, 1'b0, 4'hA);
        step();
        set_in(1'b1, 16'h0003, 16'h0004, 1'b0, 4'hB);
        step();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01 || res_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0",
                     out_valid, in_ready, res_cnt);
        end
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_back_to_back();
        test_ovf();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
